// File: rtl/arb2_pkg.sv
// Shared types and constants for the two-input round-robin arbiter.
// Imported by the grant helper and by the arbiter top.
package arb2_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    localparam int WIDTH_DEFAULT = 2;

    // The preferred source under contention is the one not served last.
    function automatic logic rr_pref(input logic last);
        return ~last;
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// Purely combinational two-way round-robin grant.
// Reusable by any 2-way arbiter that tracks the last winner.
module rr_grant2
    import arb2_pkg::*;
(
    input  logic i_v0,
    input  logic i_v1,
    input  logic i_last,
    output logic o_grant,
    output logic o_any
);

    always_comb begin
        o_grant = SRC0;
        o_any   = i_v0 | i_v1;
        unique case (1'b1)
            (i_v0 & i_v1):  o_grant = rr_pref(i_last);
            (i_v1 & ~i_v0): o_grant = SRC1;
            default:        o_grant = SRC0;
        endcase
    end

endmodule

// File: rtl/arb2_rr_sel.sv
// Two-input round-robin arbiter with a one-entry registered output buffer.
// Outputs come straight from flops; only the readies are combinational.
module arb2_rr_sel
    import arb2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic             v0,
    output logic             r0,
    input  logic [WIDTH-1:0] d1,
    input  logic             v1,
    output logic             r1,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_sel;
    logic             r_last;

    logic             w_space;
    logic             w_grant;
    logic             w_any;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_acc;
    logic [WIDTH-1:0] w_din;

    rr_grant2 u_grant (
        .i_v0    (v0),
        .i_v1    (v1),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    assign w_space = (r_state == EMPTY) | out_ready;

    // Gated by rst_n so no handshake can be seen while reset is held.
    assign r0 = rst_n & w_space & w_any & (w_grant == SRC0);
    assign r1 = rst_n & w_space & w_any & (w_grant == SRC1);

    assign w_acc0 = v0 & r0;
    assign w_acc1 = v1 & r1;
    assign w_acc  = w_acc0 | w_acc1;
    assign w_din  = w_acc1 ? d1 : d0;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY: begin
                if (w_acc)
                    w_state_nxt = FULL;
            end
            FULL: begin
                if (w_acc)
                    w_state_nxt = FULL;
                else if (out_ready)
                    w_state_nxt = EMPTY;
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_sel  <= SRC0;
            r_last <= SRC1;
        end else if (w_acc) begin
            r_data <= w_din;
            r_sel  <= w_acc1;
            r_last <= w_acc1;
        end
    end

    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign out_valid = (r_state == FULL);

endmodule

// File: tb/tb_arb2_rr_sel.sv
// Self-checking bench for arb2_rr_sel: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_arb2_rr_sel;

    logic       clk;
    logic       rst_n;
    logic [1:0] d0;
    logic       v0;
    logic       r0;
    logic [1:0] d1;
    logic       v1;
    logic       r1;
    logic [1:0] out_data;
    logic       out_sel;
    logic       out_valid;
    logic       out_ready;

    int checks;
    int failures;

    // Reference model: buffer contents and the last served source.
    bit       m_full;
    bit [1:0] m_data;
    bit       m_sel;
    bit       m_last;

    arb2_rr_sel #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d0        (d0),
        .v0        (v0),
        .r0        (r0),
        .d1        (d1),
        .v1        (v1),
        .r1        (r1),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_data = 2'b00;
        m_sel  = 1'b0;
        m_last = 1'b1;
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic cyc(input bit a0, input bit [1:0] x0,
                       input bit a1, input bit [1:0] x1,
                       input bit ordy);
        bit room;
        bit e0;
        bit e1;
        v0 = a0; d0 = x0; v1 = a1; d1 = x1; out_ready = ordy;
        #1;
        room = !m_full || ordy;
        e0 = room && a0 && (!a1 || m_last == 1'b1);
        e1 = room && a1 && (!a0 || m_last == 1'b0);
        chk("r0", r0, e0);
        chk("r1", r1, e1);
        chk("out_valid", out_valid, m_full);
        if (m_full) begin
            chk("out_data", out_data, m_data);
            chk("out_sel", out_sel, m_sel);
        end
        @(posedge clk);
        if (e0) begin
            m_full = 1; m_data = x0; m_sel = 0; m_last = 0;
        end else if (e1) begin
            m_full = 1; m_data = x1; m_sel = 1; m_last = 1;
        end else if (m_full && ordy) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        v0 = 0; v1 = 0; d0 = 0; d1 = 0; out_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sel", out_sel, 0);
        rst_n = 1'b1;

        // Single source
        cyc(1, 2'b10, 0, 2'b00, 1);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 2'b10);
        chk("single_sel", out_sel, 0);

        // Asynchronous reset mid-transfer, away from any clock edge
        v0 = 1; d0 = 2'b11; v1 = 0; out_ready = 1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_sel", out_sel, 0);
        chk("arst_r0", r0, 0);
        chk("arst_r1", r1, 0);
        model_reset();
        @(negedge clk);
        chk("arst_hold_valid", out_valid, 0);
        rst_n = 1'b1;

        // Contention fairness from a fresh reset
        for (int i = 0; i < 6; i++) begin
            cyc(1, 2'b01, 1, 2'b10, 1);
            chk("fair_sel", out_sel, i % 2);
            chk("fair_data", out_data, (i % 2) ? 2'b10 : 2'b01);
        end

        // Backpressure
        cyc(0, 2'b00, 1, 2'b11, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 2'b10, 0, 2'b00, 0);
            chk("bp_data", out_data, 2'b11);
            chk("bp_sel", out_sel, 1);
        end
        v0 = 1; d0 = 2'b10; v1 = 0; out_ready = 1;
        #1;
        chk("bp_release_r0", r0, 1);
        cyc(1, 2'b10, 0, 2'b00, 1);
        chk("bp_new_data", out_data, 2'b10);
        chk("bp_new_sel", out_sel, 0);

        // Drain without refill, then contention goes opposite last (0)
        cyc(0, 2'b00, 0, 2'b00, 1);
        chk("drain_valid", out_valid, 0);
        cyc(1, 2'b01, 1, 2'b10, 1);
        chk("drain_next_sel", out_sel, 1);
        chk("drain_next_data", out_data, 2'b10);

        // Back-to-back throughput from source 1
        for (int i = 0; i < 8; i++) begin
            cyc(0, 2'b00, 1, i[1:0], 1);
            chk("tput_valid", out_valid, 1);
            chk("tput_data", out_data, i[1:0]);
            chk("tput_sel", out_sel, 1);
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1), 2'($urandom),
                $urandom_range(0, 1), 2'($urandom),
                ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
